// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types and helpers.
// Used by the serial subtractor and its nibble slice.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int NIB = 4;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_sub4.sv
// Combinational 4-bit borrow-ripple slice.
// Four full-subtractor cells chained LSB to MSB.
module sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i])
                   | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// Serial subtractor: z = x - y - bi, one nibble
// per clock, LSB first, through one sub4 slice.
module nibble_serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bi,
  output logic [WIDTH-1:0] z,
  output logic             bo,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NN = nib_count(WIDTH);
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  sub_state_t state, state_nxt;

  logic [CW-1:0]    k;
  logic [WIDTH-1:0] xr, yr, work, work_nxt;
  logic             b;
  logic [BW-1:0]    base;
  logic [NIB-1:0]   s_a, s_b, s_d;
  logic             s_bout;
  logic             accept, step, fin;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (k == LAST) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign base = BW'({k, 2'b00});
  assign s_a  = xr[base +: NIB];
  assign s_b  = yr[base +: NIB];

  sub4 u_sub4 (
    .a    (s_a),
    .b    (s_b),
    .bin  (b),
    .d    (s_d),
    .bout (s_bout)
  );

  always_comb begin
    work_nxt = work;
    work_nxt[base +: NIB] = s_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k    <= '0;
      b    <= 1'b0;
      xr   <= '0;
      yr   <= '0;
      work <= '0;
      z    <= '0;
      bo   <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      xr <= x;
      yr <= y;
      b  <= bi;
      k  <= '0;
    end else if (step) begin
      work <= work_nxt;
      b    <= s_bout;
      k    <= fin ? '0 : k + 1'b1;
      // Only the final slice publishes, so z never shows partials.
      if (fin) begin
        z   <= work_nxt;
        bo  <= s_bout;
        ovf <= (xr[WIDTH-1] ^ yr[WIDTH-1])
             & (work_nxt[WIDTH-1] ^ xr[WIDTH-1]);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub.
// Expected values are hand-computed constants.
module tb_nibble_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x, y;
  logic        bi;
  logic [15:0] z;
  logic        bo, ovf, busy, done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_sub #(.WIDTH(16), .NIB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .bi    (bi),
    .z     (z),
    .bo    (bo),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag,
                           output int cyc,
                           output int nbusy);
    cyc   = 1;
    nbusy = 0;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string tag,
                        input logic [15:0] xv,
                        input logic [15:0] yv,
                        input logic        biv,
                        input logic [15:0] ez,
                        input logic        ebo,
                        input logic        eovf);
    int cyc, nb;
    @(negedge clk);
    x = xv; y = yv; bi = biv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = ~xv; y = ~yv; bi = ~biv;
    wait_done(tag, cyc, nb);
    check({tag, "_lat"}, cyc - 1, 4);
    check({tag, "_busy"}, nb, 4);
    check({tag, "_z"}, z, ez);
    check({tag, "_bo"}, bo, ebo);
    check({tag, "_ovf"}, ovf, eovf);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int cyc, nb, gap;
    rst_n = 1'b0; start = 1'b0;
    x = '0; y = '0; bi = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_z", z, 0);
    check("rst_flags", {bo, ovf, busy, done}, 0);
    rst_n = 1'b1;

    run_op("basic", 16'd21007, 16'd3752, 1'b0,
           16'd17255, 1'b0, 1'b0);
    run_op("neg", 16'd3752, 16'd21007, 1'b0,
           16'hBC99, 1'b1, 1'b0);
    run_op("chain", 16'h1000, 16'h0001, 1'b0,
           16'h0FFF, 1'b0, 1'b0);
    run_op("bi", 16'h0000, 16'h0000, 1'b1,
           16'hFFFF, 1'b1, 1'b0);
    run_op("ovf1", 16'h8000, 16'h0001, 1'b0,
           16'h7FFF, 1'b0, 1'b1);
    run_op("ovf2", 16'h7FFF, 16'hFFFF, 1'b0,
           16'h8000, 1'b1, 1'b1);

    // Start re-pulsed during RUN must be ignored
    @(negedge clk);
    x = 16'd500; y = 16'd123; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 16'd1; y = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", cyc, nb);
    check("ign_z", z, 16'd377);
    check("ign_bo", bo, 0);
    @(negedge clk);
    check("ign_idle", {busy, done}, 0);

    // Start held through DONE: back-to-back
    @(negedge clk);
    x = 16'h0050; y = 16'h0020; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done("b2b1", cyc, nb);
    check("b2b1_z", z, 16'h0030);
    x = 16'h0003; y = 16'h0005; bi = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_noidle", busy, 1);
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, 5);
    check("b2b2_z", z, 16'hFFFD);
    check("b2b2_bo", bo, 1);

    // Reset after E2 discards the in-flight op
    @(negedge clk);
    x = 16'h1234; y = 16'h0034; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_z", z, 0);
    check("mrst_flags", {bo, ovf, busy, done}, 0);
    nb = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nb++;
    end
    check("mrst_nodone", nb, 0);
    run_op("post", 16'h1234, 16'h0034, 1'b0,
           16'h1200, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
